// File: rtl/laser_rate_meter_if.sv
// rtl/laser_rate_meter_if.sv - laser trigger input and rate result bundle
interface laser_rate_meter_if;
  logic        LaserIn;
  logic        Clear;
  logic [31:0] LaserRate;
  logic        RateValid;
  logic        Overflow;
  logic        NoSignal;
  logic        Stable;

  modport master (
    output LaserIn, Clear,
    input  LaserRate, RateValid, Overflow, NoSignal, Stable
  );

  modport slave (
    input  LaserIn, Clear,
    output LaserRate, RateValid, Overflow, NoSignal, Stable
  );
endinterface

// File: rtl/laser_rate_meter.sv
// rtl/laser_rate_meter.sv - gated laser pulse counter with glitch filter and stability flag
module laser_rate_meter #(
  parameter int GATE_CYCLES = 50000000,
  parameter int FILTER_LEN  = 3,
  parameter int CNT_W       = 32,
  parameter int TOL         = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  laser_rate_meter_if.slave bus
);

  localparam int GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int FILT_W    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int FLUSH_LEN = FILTER_LEN + 2;
  localparam int FLUSH_W   = $clog2(FLUSH_LEN);
  localparam int CW1       = CNT_W + 1;

  localparam logic [GATE_W-1:0]  GATE_LAST  = GATE_W'(GATE_CYCLES - 1);
  localparam logic [FILT_W-1:0]  FILT_LAST  = FILT_W'(FILTER_LEN - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_LEN - 1);
  localparam logic [CNT_W:0]     TOL_EXT    = CW1'(TOL);

  typedef enum logic {FLUSH, MEASURE} state_t;

  logic               sync_1, sync_2;
  logic               level, edge_stb;
  logic [FILT_W-1:0]  filt_cnt;

  state_t             state;
  logic [FLUSH_W-1:0] flush_cnt;
  logic [GATE_W-1:0]  gate_cnt;
  logic [CNT_W-1:0]   edge_cnt, rate_q;
  logic               ovf_flag, win_seen;
  logic               valid_q, overflow_q, no_signal_q, stable_q;

  logic [CNT_W-1:0]   cnt_next;
  logic               ovf_next;
  logic [CNT_W:0]     diff, abs_diff;

  // Two-flop synchronizer for the asynchronous trigger input
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= bus.LaserIn;
      sync_2 <= sync_1;
    end
  end

  // Level flips only after FILTER_LEN consecutive disagreeing samples; rising flip emits the edge strobe
  always_ff @(posedge Clk) begin
    if (Rst) begin
      level    <= 1'b0;
      filt_cnt <= '0;
      edge_stb <= 1'b0;
    end else begin
      edge_stb <= 1'b0;
      if (sync_2 == level) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        level    <= sync_2;
        filt_cnt <= '0;
        edge_stb <= sync_2;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // Edge count including this cycle's strobe, and its distance from the last published result
  always_comb begin
    cnt_next = edge_cnt;
    ovf_next = ovf_flag;
    if (edge_stb) begin
      if (&edge_cnt) ovf_next = 1'b1;
      else           cnt_next = edge_cnt + 1'b1;
    end
    diff     = {1'b0, cnt_next} - {1'b0, rate_q};
    abs_diff = diff[CNT_W] ? (~diff + 1'b1) : diff;
  end

  // FLUSH lets the filter settle after reset/Clear; MEASURE runs back-to-back gate windows
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= FLUSH;
      flush_cnt   <= '0;
      gate_cnt    <= '0;
      edge_cnt    <= '0;
      ovf_flag    <= 1'b0;
      win_seen    <= 1'b0;
      rate_q      <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      no_signal_q <= 1'b1;
      stable_q    <= 1'b0;
    end else if (bus.Clear) begin
      state     <= FLUSH;
      flush_cnt <= '0;
      gate_cnt  <= '0;
      edge_cnt  <= '0;
      ovf_flag  <= 1'b0;
      win_seen  <= 1'b0;
      valid_q   <= 1'b0;
      stable_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        FLUSH: begin
          gate_cnt <= '0;
          if (flush_cnt == FLUSH_LAST) begin
            state     <= MEASURE;
            flush_cnt <= '0;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        MEASURE: begin
          if (gate_cnt == GATE_LAST) begin
            gate_cnt    <= '0;
            rate_q      <= cnt_next;
            overflow_q  <= ovf_next;
            no_signal_q <= (cnt_next == '0);
            valid_q     <= 1'b1;
            stable_q    <= win_seen && (abs_diff <= TOL_EXT);
            win_seen    <= 1'b1;
            edge_cnt    <= '0;
            ovf_flag    <= 1'b0;
          end else begin
            gate_cnt <= gate_cnt + 1'b1;
            edge_cnt <= cnt_next;
            ovf_flag <= ovf_next;
          end
        end
        default: state <= FLUSH;
      endcase
    end
  end

  assign bus.LaserRate = 32'(rate_q);
  assign bus.RateValid = valid_q;
  assign bus.Overflow  = overflow_q;
  assign bus.NoSignal  = no_signal_q;
  assign bus.Stable    = stable_q;

endmodule

// File: tb/tb_laser_rate_meter.sv
// tb/tb_laser_rate_meter.sv - scoreboard bench for laser_rate_meter, 32-bit and 4-bit counter variants
module tb_laser_rate_meter;

  localparam int GATE  = 100;
  localparam int FL    = 3;
  localparam int TOLV  = 1;
  localparam int FLUSH = FL + 2;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic laser_in = 1'b0;
  logic clear_in = 1'b0;

  laser_rate_meter_if bus32();
  laser_rate_meter_if bus4();

  assign bus32.LaserIn = laser_in;
  assign bus32.Clear   = clear_in;
  assign bus4.LaserIn  = laser_in;
  assign bus4.Clear    = clear_in;

  laser_rate_meter #(.GATE_CYCLES(GATE), .FILTER_LEN(FL), .CNT_W(32), .TOL(TOLV)) dut32 (
    .Clk(Clk), .Rst(Rst), .bus(bus32)
  );

  laser_rate_meter #(.GATE_CYCLES(GATE), .FILTER_LEN(FL), .CNT_W(4), .TOL(TOLV)) dut4 (
    .Clk(Clk), .Rst(Rst), .bus(bus4)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int              cyc;
    longint unsigned rate;
    bit              ovf;
    bit              nosig;
    bit              stable;
  } exp_t;

  exp_t q32[$];
  exp_t q4[$];

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic longint unsigned adiff(input longint unsigned a, input longint unsigned b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Reference model: edge times from the filter rule, window results from window arithmetic
  int              cyc = 0;
  int              anchor = 0;
  bit              sync_m [2];
  bit              filt_win [FL];
  bit              lvl, stb, used, d_s, all_diff;
  longint unsigned cnt, r4, last32, last4;
  int              done;
  exp_t            e32, e4;

  always @(posedge Clk) begin
    cyc++;
    if (Rst) begin
      anchor = cyc;
      sync_m = '{0, 0};
      for (int i = 0; i < FL; i++) filt_win[i] = 1'b0;
      lvl = 1'b0; stb = 1'b0; cnt = 0; done = 0; last32 = 0; last4 = 0;
    end else begin
      used = stb;
      d_s = sync_m[1];
      sync_m[1] = sync_m[0];
      sync_m[0] = laser_in;
      for (int i = 0; i < FL - 1; i++) filt_win[i] = filt_win[i+1];
      filt_win[FL-1] = d_s;
      all_diff = 1'b1;
      for (int i = 0; i < FL; i++) if (filt_win[i] == lvl) all_diff = 1'b0;
      stb = 1'b0;
      if (all_diff) begin
        lvl = ~lvl;
        stb = lvl;
      end
      if (clear_in) begin
        anchor = cyc; cnt = 0; done = 0;
      end else if (cyc - anchor > FLUSH) begin
        cnt += longint'(used);
        if ((cyc - anchor - FLUSH) % GATE == 0) begin
          r4 = (cnt > 15) ? 15 : cnt;
          e32.cyc = cyc; e32.rate = cnt; e32.ovf = 1'b0; e32.nosig = (cnt == 0);
          e32.stable = (done >= 1) && (adiff(cnt, last32) <= TOLV);
          e4.cyc = cyc;  e4.rate = r4;   e4.ovf = (cnt > 15); e4.nosig = (cnt == 0);
          e4.stable = (done >= 1) && (adiff(r4, last4) <= TOLV);
          q32.push_back(e32);
          q4.push_back(e4);
          last32 = cnt; last4 = r4; done++; cnt = 0;
        end
      end
    end
  end

  task automatic compare(input string tag, input exp_t e, input int c, input logic [31:0] r,
                         input logic o, input logic n, input logic s);
    check({tag, " strobe cycle"}, c, e.cyc);
    check({tag, " LaserRate"}, r, e.rate);
    check({tag, " Overflow"}, o, e.ovf);
    check({tag, " NoSignal"}, n, e.nosig);
    check({tag, " Stable"}, s, e.stable);
  endtask

  // Monitor: pop expected results whenever a DUT strobes; flag missed strobes
  always @(negedge Clk) begin
    while (q32.size() > 0 && q32[0].cyc < cyc) begin
      check("w32 missing strobe", cyc, q32[0].cyc);
      void'(q32.pop_front());
    end
    while (q4.size() > 0 && q4[0].cyc < cyc) begin
      check("w4 missing strobe", cyc, q4[0].cyc);
      void'(q4.pop_front());
    end
    if (bus32.RateValid) begin
      check("w32 strobe expected", q32.size() > 0, 1);
      if (q32.size() > 0)
        compare("w32", q32.pop_front(), cyc, bus32.LaserRate, bus32.Overflow, bus32.NoSignal, bus32.Stable);
    end
    if (bus4.RateValid) begin
      check("w4 strobe expected", q4.size() > 0, 1);
      if (q4.size() > 0)
        compare("w4", q4.pop_front(), cyc, bus4.LaserRate, bus4.Overflow, bus4.NoSignal, bus4.Stable);
    end
  end

  function automatic bit pat(input int mode, input int t);
    case (mode)
      1:       return (t % 10) < 5;
      2:       return (t % 10) < 2;
      3:       return (t % 6) < 3;
      default: return 1'b0;
    endcase
  endfunction

  int ph = 0;

  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      laser_in = pat(mode, ph);
      ph++;
      @(negedge Clk);
    end
  endtask

  task automatic wait_strobe(input int mode, input string tag, output int dt);
    bit seen;
    seen = 1'b0;
    dt = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      laser_in = pat(mode, ph);
      ph++;
      @(negedge Clk);
      dt++;
      seen = bus32.RateValid;
    end
    check({tag, " strobe seen"}, seen, 1);
  endtask

  // Idle until the next input sample lands at offset m within a window (relative to anchor)
  task automatic align(input int m);
    int n;
    n = 0;
    while (!(((cyc + 1 - anchor) % GATE == m) && (cyc + 1 - anchor >= GATE)) && n < 300) begin
      laser_in = 1'b0;
      @(negedge Clk);
      n++;
    end
    check("align reached", n < 300, 1);
  endtask

  task automatic pulse(input int hi);
    for (int i = 0; i < hi; i++) begin
      laser_in = 1'b1;
      @(negedge Clk);
    end
    laser_in = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " LaserRate"}, bus32.LaserRate, 0);
    check({tag, " RateValid"}, bus32.RateValid, 0);
    check({tag, " Overflow"}, bus32.Overflow, 0);
    check({tag, " NoSignal"}, bus32.NoSignal, 1);
    check({tag, " Stable"}, bus32.Stable, 0);
    check({tag, " w4 LaserRate"}, bus4.LaserRate, 0);
  endtask

  int dt;
  int cl;
  int n_wait;
  int run_left;
  bit lvl_r;

  initial begin
    Rst = 1'b1;
    repeat (3) @(negedge Clk);
    check_reset_state("reset");
    Rst = 1'b0;

    // Pulse train, period 10: first strobe 105 cycles after release, then steady 10/window
    wait_strobe(1, "first", dt);
    check("first strobe latency", dt, 105);
    run(250, 1);
    check("pulse LaserRate", bus32.LaserRate, 10);
    check("pulse NoSignal", bus32.NoSignal, 0);
    check("pulse Stable", bus32.Stable, 1);

    // Clear at gate count 50 while LaserRate=10
    n_wait = 0;
    while (!(((cyc - anchor - FLUSH - 50) % GATE == 0) && (cyc - anchor > FLUSH + 50)) && n_wait < 300) begin
      laser_in = pat(1, ph); ph++;
      @(negedge Clk);
      n_wait++;
    end
    check("clear align reached", n_wait < 300, 1);
    clear_in = 1'b1;
    laser_in = pat(1, ph); ph++;
    @(negedge Clk);
    clear_in = 1'b0;
    cl = cyc;
    check("clear LaserRate held", bus32.LaserRate, 10);
    check("clear Stable", bus32.Stable, 0);
    check("clear RateValid", bus32.RateValid, 0);
    wait_strobe(1, "after clear", dt);
    check("strobe after clear", cyc - cl, 105);

    // Short glitches must not count
    run(350, 2);
    check("glitch LaserRate", bus32.LaserRate, 0);
    check("glitch NoSignal", bus32.NoSignal, 1);

    // Edge counted on a terminal cycle, then an edge on a window's first cycle
    run(10, 0);
    align(0);
    pulse(5);
    run(10, 0);
    align(1);
    pulse(5);
    wait_strobe(0, "boundary", dt);
    check("boundary first-cycle edge", bus32.LaserRate, 1);

    // Saturation of the 4-bit counter, then recovery
    run(120, 3);
    wait_strobe(3, "overflow", dt);
    check("w4 saturated LaserRate", bus4.LaserRate, 15);
    check("w4 Overflow set", bus4.Overflow, 1);
    run(10, 0);
    align(1);
    for (int i = 0; i < 30; i++) begin
      laser_in = (i % 10) < 5;
      @(negedge Clk);
    end
    laser_in = 1'b0;
    wait_strobe(0, "recover", dt);
    check("w4 recover LaserRate", bus4.LaserRate, 3);
    check("w4 Overflow cleared", bus4.Overflow, 0);

    // Random runs with occasional Clear and one mid-window reset
    run_left = 0;
    lvl_r = 1'b0;
    for (int i = 0; i < 900; i++) begin
      if (run_left == 0) begin
        lvl_r = 1'($urandom_range(0, 1));
        run_left = $urandom_range(1, 8);
      end
      laser_in = lvl_r;
      run_left--;
      clear_in = ($urandom_range(0, 299) == 0);
      Rst = (i >= 450 && i < 452);
      @(negedge Clk);
      if (i == 451) check_reset_state("mid-window reset");
    end
    clear_in = 1'b0;
    Rst = 1'b0;

    wait_strobe(0, "drain", dt);
    run(3, 0);
    check("w32 queue empty", q32.size(), 0);
    check("w4 queue empty", q4.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

endmodule
